// File: rtl/update_loop_ctrl.sv
// update_loop_ctrl: runs a fixed three-register update loop for a programmable
// number of iterations, then pulses done for one cycle and holds the results.
`timescale 1ns/1ps
module update_loop_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8,
  parameter int ADD_K = 10,
  parameter int SUB_K = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] iter,
  input  logic [WIDTH-1:0] a_init,
  input  logic [WIDTH-1:0] b_init,
  input  logic [WIDTH-1:0] d_init,
  input  logic [WIDTH-1:0] c_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] d_out,
  output logic [WIDTH-1:0] c_out,
  output logic [CNT_W-1:0] iter_cnt,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ADD_KV = WIDTH'(ADD_K);
  localparam logic [WIDTH-1:0] SUB_KV = WIDTH'(SUB_K);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [WIDTH-1:0] c_reg, c_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] iter_cap_reg, iter_cap_next;
  logic [CNT_W-1:0] cnt_inc;

  // The captured count is at most 2^CNT_W-1, so the run ends before this wraps.
  assign cnt_inc = cnt_reg + 1'b1;

  // State register; reset takes effect immediately, independent of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: start is only looked at in IDLE, DONE always returns to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (iter == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt_inc == iter_cap_reg) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode taken from the registered state only.
  always_comb begin
    busy = (state_reg == RUN);
    done = (state_reg == DONE);
  end

  // Datapath next values: load on start, simultaneous update in RUN, hold otherwise.
  always_comb begin
    a_next        = a_reg;
    b_next        = b_reg;
    d_next        = d_reg;
    c_next        = c_reg;
    cnt_next      = cnt_reg;
    iter_cap_next = iter_cap_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next        = a_init;
          b_next        = b_init;
          d_next        = d_init;
          c_next        = c_in;
          iter_cap_next = iter;
          cnt_next      = '0;
        end
      end
      RUN: begin
        // All three use the pre-edge register values; sums wrap modulo 2^WIDTH.
        a_next   = b_reg + c_reg;
        d_next   = a_reg - SUB_KV;
        b_next   = d_reg + ADD_KV;
        cnt_next = cnt_inc;
      end
      default: ;
    endcase
  end

  // Datapath registers; cleared asynchronously so a reset mid-run aborts cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg        <= '0;
      b_reg        <= '0;
      d_reg        <= '0;
      c_reg        <= '0;
      cnt_reg      <= '0;
      iter_cap_reg <= '0;
    end else begin
      a_reg        <= a_next;
      b_reg        <= b_next;
      d_reg        <= d_next;
      c_reg        <= c_next;
      cnt_reg      <= cnt_next;
      iter_cap_reg <= iter_cap_next;
    end
  end

  assign a_out    = a_reg;
  assign b_out    = b_reg;
  assign d_out    = d_reg;
  assign c_out    = c_reg;
  assign iter_cnt = cnt_reg;

endmodule

// File: tb/tb_update_loop_ctrl.sv
// Directed testbench for update_loop_ctrl with hand-computed expected values.
`timescale 1ns/1ps
module tb_update_loop_ctrl;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] iter;
  logic [WIDTH-1:0] a_init, b_init, d_init, c_in;
  logic [WIDTH-1:0] a_out, b_out, d_out, c_out;
  logic [CNT_W-1:0] iter_cnt;
  logic             busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cycles;
  int done_seen;

  update_loop_ctrl #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W),
    .ADD_K(10),
    .SUB_K(3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .iter    (iter),
    .a_init  (a_init),
    .b_init  (b_init),
    .d_init  (d_init),
    .c_in    (c_in),
    .a_out   (a_out),
    .b_out   (b_out),
    .d_out   (d_out),
    .c_out   (c_out),
    .iter_cnt(iter_cnt),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports a mismatch.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one rising edge and settle 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                            input logic [31:0] ed, input logic [7:0] ecnt);
    check({tag, ".a"}, 64'(a_out), 64'(ea));
    check({tag, ".b"}, 64'(b_out), 64'(eb));
    check({tag, ".d"}, 64'(d_out), 64'(ed));
    check({tag, ".cnt"}, 64'(iter_cnt), 64'(ecnt));
  endtask

  task automatic load(input logic [7:0] n, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] d, input logic [31:0] c);
    iter   = n;
    a_init = a;
    b_init = b;
    d_init = d;
    c_in   = c;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    load(8'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    #3;
    // Reset state
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check_regs("rst", 32'd0, 32'd0, 32'd0, 8'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();

    // iter=1
    load(8'd1, 32'd30, 32'd20, 32'd5, 32'd15);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("i1.busy", 64'(busy), 64'd1);
    check_regs("i1.load", 32'd30, 32'd20, 32'd5, 8'd0);
    tick();
    check("i1.done", 64'(done), 64'd1);
    check("i1.busy_lo", 64'(busy), 64'd0);
    check_regs("i1.final", 32'd35, 32'd15, 32'd27, 8'd1);
    check("i1.c", 64'(c_out), 64'd15);
    tick();
    check("i1.done_pulse", 64'(done), 64'd0);
    check_regs("i1.hold", 32'd35, 32'd15, 32'd27, 8'd1);

    // iter=4, with input changes during RUN that must be ignored
    busy_cycles = 0;
    load(8'd4, 32'd30, 32'd20, 32'd5, 32'd15);
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_cycles += int'(busy);
    load(8'd1, 32'd999, 32'd888, 32'd777, 32'd0);
    tick();
    busy_cycles += int'(busy);
    check_regs("i4.it1", 32'd35, 32'd15, 32'd27, 8'd1);
    tick();
    busy_cycles += int'(busy);
    check_regs("i4.it2", 32'd30, 32'd37, 32'd32, 8'd2);
    tick();
    busy_cycles += int'(busy);
    check_regs("i4.it3", 32'd52, 32'd42, 32'd27, 8'd3);
    check("i4.done_early", 64'(done), 64'd0);
    tick();
    busy_cycles += int'(busy);
    check("i4.done", 64'(done), 64'd1);
    check_regs("i4.final", 32'd57, 32'd37, 32'd49, 8'd4);
    check("i4.c", 64'(c_out), 64'd15);
    check("i4.busy_cycles", 64'(busy_cycles), 64'd4);
    tick();
    check("i4.idle", 64'(done), 64'd0);

    // iter=0: straight to DONE
    load(8'd0, 32'd30, 32'd20, 32'd5, 32'd15);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("i0.done", 64'(done), 64'd1);
    check("i0.busy", 64'(busy), 64'd0);
    check_regs("i0.vals", 32'd30, 32'd20, 32'd5, 8'd0);
    check("i0.c", 64'(c_out), 64'd15);
    tick();
    check("i0.done_lo", 64'(done), 64'd0);
    check("i0.busy_lo", 64'(busy), 64'd0);

    // Wrap-around
    load(8'd1, 32'd0, 32'h7FFF_FFFF, 32'd0, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("wrap.done", 64'(done), 64'd1);
    check("wrap.a", 64'(a_out), 64'h8000_0000);
    check("wrap.d", 64'(d_out), 64'hFFFF_FFFD);
    check("wrap.b", 64'(b_out), 64'd10);
    tick();

    // Reset mid-run (during iteration 2 of 4)
    load(8'd4, 32'd30, 32'd20, 32'd5, 32'd15);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("ab.busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ab.async_busy", 64'(busy), 64'd0);
    check("ab.async_done", 64'(done), 64'd0);
    check("ab.async_c", 64'(c_out), 64'd0);
    check_regs("ab.async", 32'd0, 32'd0, 32'd0, 8'd0);
    done_seen = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      done_seen += int'(done);
    end
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      done_seen += int'(done) + int'(busy);
    end
    check("ab.no_done", 64'(done_seen), 64'd0);

    // start held high through a run: re-arms one IDLE edge after DONE
    load(8'd2, 32'd30, 32'd20, 32'd5, 32'd15);
    start = 1'b1;
    tick();
    check("hold.busy0", 64'(busy), 64'd1);
    load(8'd7, 32'd1, 32'd1, 32'd1, 32'd1);
    start = 1'b0;
    #2 start = 1'b1;
    tick();
    check("hold.busy1", 64'(busy), 64'd1);
    check("hold.cnt1", 64'(iter_cnt), 64'd1);
    tick();
    check("hold.done", 64'(done), 64'd1);
    check_regs("hold.final", 32'd30, 32'd37, 32'd32, 8'd2);
    load(8'd1, 32'd30, 32'd20, 32'd5, 32'd15);
    tick();
    check("hold.idle_busy", 64'(busy), 64'd0);
    check("hold.idle_done", 64'(done), 64'd0);
    tick();
    start = 1'b0;
    check("hold.rerun_busy", 64'(busy), 64'd1);
    check_regs("hold.reload", 32'd30, 32'd20, 32'd5, 8'd0);
    tick();
    check("hold.rerun_done", 64'(done), 64'd1);
    check_regs("hold.rerun", 32'd35, 32'd15, 32'd27, 8'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/update_loop_ctrl.md
UPDATE_LOOP_CTRL -- requirements
Module: update_loop_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the data width of all datapath registers and ports (two's complement).
REQ-002 SHALL have parameter CNT_W, default 8, giving the width of the iteration count.
REQ-003 SHALL have parameter ADD_K, default 10, the constant added in the b update.
REQ-004 SHALL have parameter SUB_K, default 3, the constant subtracted in the d update.
REQ-005 SHALL have ports:
  - clk       in   1      -- single clock; all state changes on rising edge.
  - rst_n     in   1      -- asynchronous, active-low reset.
  - start     in   1      -- request to run a sequence; sampled only in IDLE.
  - iter      in   CNT_W  -- number of update iterations to run.
  - a_init    in   WIDTH  -- initial value for register a.
  - b_init    in   WIDTH  -- initial value for register b.
  - d_init    in   WIDTH  -- initial value for register d.
  - c_in      in   WIDTH  -- operand c, captured at start.
  - a_out     out  WIDTH  -- current value of a.
  - b_out     out  WIDTH  -- current value of b.
  - d_out     out  WIDTH  -- current value of d.
  - c_out     out  WIDTH  -- captured c.
  - iter_cnt  out  CNT_W  -- iterations completed in the current or last run.
  - busy      out  1      -- high in LOAD-to-RUN span (state RUN).
  - done      out  1      -- one-cycle pulse, high in state DONE.

Function
REQ-006 SHALL implement three states: IDLE, RUN, DONE.
REQ-007 In IDLE with start=1 at a rising edge, SHALL load a/b/d from a_init/b_init/d_init, capture c_in and iter, and clear iter_cnt to 0.
REQ-008 At that same edge SHALL go to RUN if iter>0, else to DONE.
REQ-009 In RUN, each rising edge SHALL perform one iteration, with all three updates using pre-edge values simultaneously:
  - a <= b + c
  - d <= a - SUB_K
  - b <= d + ADD_K
REQ-010 Each RUN edge SHALL increment iter_cnt by 1.
REQ-011 The RUN edge on which iter_cnt becomes equal to the captured iter SHALL move the block to DONE.
REQ-012 From DONE, the next edge SHALL return the block to IDLE unconditionally.
REQ-013 Latency: for captured iter=N, done SHALL be high in the cycle after the (N+1)th edge counted from the start-sampling edge; for N=0, after the first edge.
REQ-014 Arithmetic SHALL wrap modulo 2^WIDTH, with no saturation and no overflow flag.
REQ-015 start SHALL be ignored in RUN and DONE; a start held high SHALL begin a new run at the first IDLE edge after DONE.
REQ-016 Changes to iter, a_init, b_init, d_init and c_in during RUN SHALL have no effect on the active run.
REQ-017 In IDLE and DONE, a, b, d, c and iter_cnt SHALL hold their values, so the last results remain readable.
REQ-018 busy SHALL equal (state==RUN) and done SHALL equal (state==DONE); both are registered-state decodes with no combinational path from start.
REQ-019 iter_cnt SHALL not wrap during a run, because it terminates at iter ≤ 2^CNT_W-1.

Reset
REQ-020 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE and zero a, b, c, d and iter_cnt, making busy=0 and done=0.
REQ-021 Reset asserted mid-RUN SHALL abort the run with no done pulse.
REQ-022 After rst_n deasserts, the block SHALL wait for a fresh start.

Verification
REQ-023 a_init=30, b_init=20, c_in=15, d_init=5, iter=1 -> done pulse with a=35, d=27, b=15, iter_cnt=1.
REQ-024 Same inits, iter=4 -> after iteration 2: a=30, d=32, b=37; after iteration 3: a=52, d=27, b=42; final: a=57, d=49, b=37, iter_cnt=4; busy high for exactly 4 cycles.
REQ-025 iter=0, same inits -> done on the cycle after the start edge; busy never high; outputs 30/20/5 with c=15.
REQ-026 WIDTH=32, b_init=32'h7FFFFFFF, c_in=1, iter=1 -> a=32'h80000000 (wrap).
REQ-027 Scenario: rst_n pulsed low mid-RUN (iteration 2 of 4) -> all outputs 0 asynchronously and no done pulse; then start held high through the run -> second run begins one edge after DONE, and start pulses during RUN are ignored.
